regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 117 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter: merges three register-file write requesters
// (ALU, MEM, MUL) onto a single registered write port, one accept per cycle.
module regfile_wb_arbiter #(
  parameter int REG_ADDR = 5,
  parameter int REG_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req_valid,
  input  logic [3*REG_ADDR-1:0] req_wreg,
  input  logic [3*REG_SIZE-1:0] req_wdata,
  output logic [2:0]            req_ready,
  output logic                  regwrite,
  output logic [REG_ADDR-1:0]   wreg,
  output logic [REG_SIZE-1:0]   wdata,
  output logic [1:0]            grant_id,
  output logic [7:0]            contention_cnt
);

  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic                regwrite_q, regwrite_d;
  logic [REG_ADDR-1:0] wreg_q, wreg_d;
  logic [REG_SIZE-1:0] wdata_q, wdata_d;
  logic [1:0]          grant_id_q, grant_id_d;
  logic [7:0]          contention_cnt_q, contention_cnt_d;

  logic [2:0]          rot_valid;
  logic [2:0]          grant_sum;
  logic [1:0]          grant_idx;
  logic                transfer;
  logic                contended;
  logic [REG_ADDR-1:0] sel_wreg;
  logic [REG_SIZE-1:0] sel_wdata;

  // Rotate req_valid so bit 0 is the requester at rr_ptr, pick the first set
  // bit, then map the offset back to an absolute requester index.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves one unassigned would infer a latch.
    rot_valid = req_valid;
    grant_sum = '0;
    grant_idx = '0;
    transfer  = 1'b0;
    req_ready = '0;
    case (rr_ptr_q)
      2'd1:    rot_valid = {req_valid[0], req_valid[2], req_valid[1]};
      2'd2:    rot_valid = {req_valid[1], req_valid[0], req_valid[2]};
      default: rot_valid = req_valid;
    endcase
    if (rot_valid[0])      grant_sum = {1'b0, rr_ptr_q};
    else if (rot_valid[1]) grant_sum = {1'b0, rr_ptr_q} + 3'd1;
    else                   grant_sum = {1'b0, rr_ptr_q} + 3'd2;
    if (grant_sum >= 3'd3) grant_sum = grant_sum - 3'd3;
    grant_idx = grant_sum[1:0];
    // Reset gates the grant so a pending request is never accepted while held.
    transfer = reset && (|req_valid);
    if (transfer) req_ready = 3'b001 << grant_idx;
  end

  always_comb begin
    sel_wreg         = req_wreg[0 +: REG_ADDR];
    sel_wdata        = req_wdata[0 +: REG_SIZE];
    rr_ptr_d         = rr_ptr_q;
    regwrite_d       = 1'b0;
    wreg_d           = wreg_q;
    wdata_d          = wdata_q;
    grant_id_d       = grant_id_q;
    contention_cnt_d = contention_cnt_q;
    contended        = (req_valid[0] & req_valid[1]) | (req_valid[0] & req_valid[2]) |
                       (req_valid[1] & req_valid[2]);
    case (grant_idx)
      2'd1: begin
        sel_wreg  = req_wreg[REG_ADDR +: REG_ADDR];
        sel_wdata = req_wdata[REG_SIZE +: REG_SIZE];
      end
      2'd2: begin
        sel_wreg  = req_wreg[2*REG_ADDR +: REG_ADDR];
        sel_wdata = req_wdata[2*REG_SIZE +: REG_SIZE];
      end
      default: ;
    endcase
    if (transfer) begin
      rr_ptr_d   = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
      wreg_d     = sel_wreg;
      wdata_d    = sel_wdata;
      grant_id_d = grant_idx;
      // Index 0 is hard-wired zero: accept the request but suppress the write.
      regwrite_d = |sel_wreg;
    end
    if (contended && contention_cnt_q != 8'hFF) contention_cnt_d = contention_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!reset) begin
      rr_ptr_q         <= '0;
      regwrite_q       <= 1'b0;
      wreg_q           <= '0;
      wdata_q          <= '0;
      grant_id_q       <= '0;
      contention_cnt_q <= '0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      regwrite_q       <= regwrite_d;
      wreg_q           <= wreg_d;
      wdata_q          <= wdata_d;
      grant_id_q       <= grant_id_d;
      contention_cnt_q <= contention_cnt_d;
    end
  end

  assign regwrite       = regwrite_q;
  assign wreg           = wreg_q;
  assign wdata          = wdata_q;
  assign grant_id       = grant_id_q;
  assign contention_cnt = contention_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus
// randomized traffic against a behavioural round-robin reference model.
module tb_regfile_wb_arbiter;

  localparam int RA = 5;
  localparam int RS = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       req_valid;
  logic [3*RA-1:0]  req_wreg;
  logic [3*RS-1:0]  req_wdata;
  logic [2:0]       req_ready;
  logic             regwrite;
  logic [RA-1:0]    wreg;
  logic [RS-1:0]    wdata;
  logic [1:0]       grant_id;
  logic [7:0]       contention_cnt;

  regfile_wb_arbiter #(.REG_ADDR(RA), .REG_SIZE(RS)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_wreg       (req_wreg),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .regwrite       (regwrite),
    .wreg           (wreg),
    .wdata          (wdata),
    .grant_id       (grant_id),
    .contention_cnt (contention_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int          m_rr = 0;
  logic        m_regwrite = 1'b0;
  logic [RA-1:0] m_wreg = '0;
  logic [RS-1:0] m_wdata = '0;
  int          m_gid = 0;
  int          m_cnt = 0;
  int          last_g = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // One clock cycle: drive at negedge, check ready, clock, check registered outputs.
  task automatic cycle(input logic rst_v, input logic [2:0] v,
                       input logic [3*RA-1:0] wr, input logic [3*RS-1:0] wd);
    int g;
    logic [2:0] exp_ready;
    @(negedge clk);
    reset     = rst_v;
    req_valid = v;
    req_wreg  = wr;
    req_wdata = wd;
    #1;
    g = -1;
    if (rst_v) begin
      for (int k = 0; k < 3; k++) begin
        automatic int i = (m_rr + k) % 3;
        if (g < 0 && v[i]) g = i;
      end
    end
    exp_ready = (g < 0) ? 3'b000 : 3'(1 << g);
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    @(posedge clk);
    #1;
    if (!rst_v) begin
      m_rr = 0; m_regwrite = 1'b0; m_wreg = '0; m_wdata = '0; m_gid = 0; m_cnt = 0;
    end else begin
      if ($countones(v) >= 2 && m_cnt < 255) m_cnt++;
      if (g >= 0) begin
        m_wreg     = wr[g*RA +: RA];
        m_wdata    = wd[g*RS +: RS];
        m_gid      = g;
        m_regwrite = (m_wreg != 0);
        m_rr       = (g + 1) % 3;
      end else begin
        m_regwrite = 1'b0;
      end
    end
    check("regwrite", 64'(regwrite), 64'(m_regwrite));
    check("wreg", 64'(wreg), 64'(m_wreg));
    check("wdata", 64'(wdata), 64'(m_wdata));
    check("grant_id", 64'(grant_id), 64'(m_gid));
    check("contention_cnt", 64'(contention_cnt), 64'(m_cnt));
    last_g = g;
  endtask

  task automatic do_reset();
    cycle(1'b0, 3'b000, '0, '0);
    cycle(1'b0, 3'b000, '0, '0);
  endtask

  int          order[6];
  logic        p[3];
  logic [RA-1:0] pw[3];
  logic [RS-1:0] pd[3];

  initial begin
    reset = 1'b0; req_valid = '0; req_wreg = '0; req_wdata = '0;

    // Reset state
    do_reset();
    check("reset_regwrite", 64'(regwrite), 64'd0);
    check("reset_cnt", 64'(contention_cnt), 64'd0);

    // Single MEM request
    cycle(1'b1, 3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0});
    check("mem_gid", 64'(grant_id), 64'd1);
    check("mem_wdata", 64'(wdata), 64'hDEADBEEF);
    cycle(1'b1, 3'b000, '0, '0);
    check("mem_idle_regwrite", 64'(regwrite), 64'd0);

    // Three-way contention from reset
    do_reset();
    for (int n = 0; n < 6; n++) begin
      cycle(1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h300 + 32'(n), 32'h200 + 32'(n), 32'h100 + 32'(n)});
      order[n] = last_g;
    end
    for (int n = 0; n < 6; n++) check("rr_order", 64'(order[n]), 64'(n % 3));
    check("rr_cnt6", 64'(contention_cnt), 64'd6);

    // Write to register zero
    do_reset();
    cycle(1'b1, 3'b001, {5'd0, 5'd0, 5'd0}, {32'd0, 32'd0, 32'h1234});
    check("zero_regwrite", 64'(regwrite), 64'd0);
    check("zero_gid", 64'(grant_id), 64'd0);

    // Same destination with rr_ptr = 2
    do_reset();
    cycle(1'b1, 3'b010, {5'd0, 5'd9, 5'd0}, {32'd0, 32'h99, 32'd0});
    cycle(1'b1, 3'b101, {5'd7, 5'd0, 5'd7}, {32'h22, 32'd0, 32'h11});
    check("same_first", 64'(wdata), 64'h22);
    cycle(1'b1, 3'b001, {5'd0, 5'd0, 5'd7}, {32'd0, 32'd0, 32'h11});
    check("same_second", 64'(wdata), 64'h11);
    check("same_second_gid", 64'(grant_id), 64'd0);

    // Reset mid-operation with rr_ptr = 1
    do_reset();
    cycle(1'b1, 3'b001, {5'd0, 5'd0, 5'd4}, {32'd0, 32'd0, 32'h44});
    cycle(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1});
    check("midrst_regwrite", 64'(regwrite), 64'd0);
    cycle(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1});
    cycle(1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1});
    check("midrst_first_grant", 64'(last_g), 64'd0);

    // Counter saturation
    do_reset();
    for (int n = 0; n < 300; n++)
      cycle(1'b1, 3'b011, {5'd0, 5'd6, 5'd8}, {32'd0, 32'(n), 32'(n + 1000)});
    check("sat_cnt", 64'(contention_cnt), 64'd255);

    // Randomized traffic; requests are held until accepted
    do_reset();
    for (int i = 0; i < 3; i++) p[i] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [2:0]      v;
      logic [3*RA-1:0] wr;
      logic [3*RS-1:0] wd;
      logic            r;
      for (int i = 0; i < 3; i++) begin
        if (!p[i] && $urandom_range(0, 99) < 60) begin
          p[i]  = 1'b1;
          pw[i] = RA'($urandom_range(0, 31));
          pd[i] = $urandom;
        end
        v[i] = p[i];
      end
      wr = {pw[2], pw[1], pw[0]};
      wd = {pd[2], pd[1], pd[0]};
      r  = ($urandom_range(0, 39) != 0);
      cycle(r, v, wr, wd);
      if (last_g >= 0) p[last_g] = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
